pet_battle_engine: RTL and testbench
====================================

// Module: pet_battle_engine
// PURPOSE
//   Parametrised two-player pet battle controller; successor to the fixed 4-pet/3-bit select FSM.
//   Generates NUM_PETS pets per player from a random stream and handles key-driven pet selection.
//   Resolves turn-based combat (damage, fainting, forced reselect) and declares a winner.
//   Sits between keyboard_tracker (kstates) / RNG (rand_in) and the VGA/HEX display logic.
// PARAMETERS
//   NUM_PETS  4  pets per player (2..8)
//   STAT_W    3  bits per stat (HP, DEF, ATK); each stat range 1..2^STAT_W-1
//   ATK_KEY   14 kstates code that advances one attack turn
// PORTS
//   clk       in   1                   system clock (CLOCK_50)
//   reset     in   1                   async active-low reset
//   kstates   in   5                   current key code, 0 = no key held
//   start     in   1                   begin/restart game (level, sampled)
//   rand_in   in   3*STAT_W            random word {atk,def,hp}
//   rand_vld  in   1                   rand_in valid this cycle
//   rd_idx    in   $clog2(2*NUM_PETS)  stat read index (0..NUM_PETS-1 = P1, rest = P2)
//   rd_stats  out  3*STAT_W            combinational stats of pet rd_idx {atk,def,hp}
//   state     out  4                   FSM state code
//   p1_sel    out  $clog2(NUM_PETS)    P1 active pet
//   p2_sel    out  $clog2(NUM_PETS)    P2 active pet
//   winner    out  2                   0 none, 1 P1, 2 P2
//   done      out  1                   high in S_OVER
// BEHAVIOUR
//   Reset (async, reset==0): state=S_IDLE, all pet stats=0, p1_sel=p2_sel=0, winner=0, done=0,
//     gen counter=0, key_armed=0; applies mid-operation, no partial state retained.
//   key_armed: set when kstates==0, cleared when a key is consumed; a key acts only if armed
//     (one action per press; held key never repeats).
//   S_IDLE: start=1 -> S_GEN.
//   S_GEN: per cycle with rand_vld, write pet[gen] = rand_in; any zero field forced to 1;
//     gen increments; after pet 2*NUM_PETS-1 -> S_SEL1. No rand_vld -> hold.
//   S_SEL1: armed key k in 1..NUM_PETS selects P1 pet k-1; HP==0 -> ignored, stay;
//     valid -> p1_sel=k-1, S_SEL2. Other keys ignored.
//   S_SEL2: keys NUM_PETS+1..2*NUM_PETS select P2 pet likewise -> S_ATK1.
//   S_ATK1/S_ATK2: armed ATK_KEY -> attacker hits defender's active pet:
//     dmg = (atk>def) ? atk-def : 1; hp_new = (hp>dmg) ? hp-dmg : 0 (saturating, no wrap).
//     Defender hp_new>0 -> other ATK state. hp_new==0 and defender has a live pet
//     -> defender's SEL state, then back to the ATK state of the player who just reselected.
//     hp_new==0 and none live -> S_OVER, winner = attacker.
//     Live-pet check uses post-update HP (same cycle).
//   S_OVER: done=1, winner held; start=1 -> clear stats/winner, S_GEN.
//   start outside S_IDLE/S_OVER ignored.
//   Simultaneous rand_vld during non-GEN states ignored. All state/stat updates are 1-cycle.
// CONFIGURATION
//   PB_CRIT_EN defined: in ATK states rand_in[0]==1 with rand_vld doubles dmg, saturating at
//     2^STAT_W-1. Undefined: dmg never doubled; rand_in ignored outside S_GEN.
// STRUCTURE
//   pet_battle_pkg: state encoding (S_IDLE=0,S_GEN=1,S_SEL1=2,S_SEL2=3,S_ATK1=4,S_ATK2=5,S_OVER=6),
//     winner codes, key-code constants, stat field offsets.
//   Sub-module pet_damage_calc: combinational (atk,def,hp[,crit]) -> hp_new, fainted.
//   Stats in 2*NUM_PETS x 3*STAT_W register array; instantiated once per attack direction, muxed.
// TESTING (NUM_PETS=4, STAT_W=3, ATK_KEY=14)
//   Reset mid-S_ATK1 -> state=0, winner=0, rd_stats=0 for all idx, done=0.
//   Gen: rand_in 9'b011_010_101 then 9'b000_000_000 -> pet0 {3,2,5}, pet1 {1,1,1}.
//   Select: key 2 held 5 cycles -> p1_sel=1 once; key 2 with pet1 HP=0 -> stays S_SEL1.
//   Damage: atk 3 vs def 2, hp 5 -> 4; atk 1 vs def 7, hp 1 -> 0, defender forced to SEL.
//   Game over: P2 last live pet hp 1 hit by P1 -> S_OVER, winner=1, done=1; start -> S_GEN.
//   PB_CRIT_EN: atk 7 def 1, rand_in[0]=1 -> dmg 7 (saturated 12->7), hp 7 -> 0.

Source files
------------

// File: rtl/pet_battle_pkg.sv
// Shared encodings for the pet battle engine: FSM states, winner codes, key codes, stat fields.
package pet_battle_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_GEN  = 4'd1,
    S_SEL1 = 4'd2,
    S_SEL2 = 4'd3,
    S_ATK1 = 4'd4,
    S_ATK2 = 4'd5,
    S_OVER = 4'd6
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam logic [4:0] KEY_NONE = 5'd0;

  // Field positions inside a {atk,def,hp} stat word, in units of STAT_W.
  localparam int FLD_HP  = 0;
  localparam int FLD_DEF = 1;
  localparam int FLD_ATK = 2;
  localparam int NUM_FLD = 3;

endpackage

// File: rtl/pet_damage_calc.sv
// Combinational damage resolution for one attacker/defender pair; saturating, never wraps.
module pet_damage_calc #(
  parameter int STAT_W = 3
) (
  input  logic [STAT_W-1:0] atk,
  input  logic [STAT_W-1:0] def,
  input  logic [STAT_W-1:0] hp,
  input  logic              crit,
  output logic [STAT_W-1:0] hp_new,
  output logic              fainted
);

  localparam logic [STAT_W:0] STAT_MAX = {1'b0, {STAT_W{1'b1}}};

  logic [STAT_W-1:0] base_dmg;
  logic [STAT_W:0]   dbl_dmg;
  logic [STAT_W-1:0] dmg;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    base_dmg = (atk > def) ? atk - def : STAT_W'(1);
    dbl_dmg  = {base_dmg, 1'b0};
    dmg      = base_dmg;
    if (crit) dmg = (dbl_dmg > STAT_MAX) ? STAT_MAX[STAT_W-1:0] : dbl_dmg[STAT_W-1:0];
    hp_new   = (hp > dmg) ? hp - dmg : '0;
    fainted  = (hp_new == '0);
  end

endmodule

// File: rtl/pet_battle_engine.sv
// Two-player pet battle controller: random pet generation, keyed selection, turn combat.
// Optional build macro PB_CRIT_EN enables critical hits from rand_in[0] during attack turns.
module pet_battle_engine
  import pet_battle_pkg::*;
#(
  parameter int NUM_PETS = 4,
  parameter int STAT_W   = 3,
  parameter int ATK_KEY  = 14
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4:0]                      kstates,
  input  logic                            start,
  input  logic [3*STAT_W-1:0]             rand_in,
  input  logic                            rand_vld,
  input  logic [$clog2(2*NUM_PETS)-1:0]   rd_idx,
  output logic [3*STAT_W-1:0]             rd_stats,
  output logic [3:0]                      state,
  output logic [$clog2(NUM_PETS)-1:0]     p1_sel,
  output logic [$clog2(NUM_PETS)-1:0]     p2_sel,
  output logic [1:0]                      winner,
  output logic                            done
);

  localparam int SEL_W  = $clog2(NUM_PETS);
  localparam int IDX_W  = $clog2(2*NUM_PETS);
  localparam int WORD_W = NUM_FLD*STAT_W;
  localparam int TOTAL  = 2*NUM_PETS;

  function automatic logic [STAT_W-1:0] fld(input logic [WORD_W-1:0] w, input int f);
    return w[f*STAT_W +: STAT_W];
  endfunction

  function automatic logic [WORD_W-1:0] force_nonzero(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    for (int f = 0; f < NUM_FLD; f++)
      if (w[f*STAT_W +: STAT_W] == '0) r[f*STAT_W +: STAT_W] = STAT_W'(1);
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] p1_idx(input logic [SEL_W-1:0] s);
    return IDX_W'(s);
  endfunction

  function automatic logic [IDX_W-1:0] p2_idx(input logic [SEL_W-1:0] s);
    return IDX_W'(NUM_PETS) + IDX_W'(s);
  endfunction

  state_t              cur_state, nxt_state;
  logic [WORD_W-1:0]   pets [TOTAL];
  logic [IDX_W-1:0]    gen_cnt;
  logic                key_armed, resel;

  logic                key_fire, k1_range, k2_range, sel1_ok, sel2_ok;
  logic                atk_hit, atk1_turn, gen_last;
  logic [SEL_W-1:0]    k1_sel, k2_sel;
  logic [WORD_W-1:0]   p1_word, p2_word;
  logic [STAT_W-1:0]   hp_new_p1, hp_new_p2, hp_new;
  logic                fainted_p1, fainted_p2, def_fainted;
  logic                p1_other_live, p2_other_live, def_other_live;
  logic [IDX_W-1:0]    def_idx;
  logic                crit;

  // A key acts once per press: it must be seen released before it can fire again.
  assign key_fire  = key_armed && (kstates != KEY_NONE);
  assign k1_range  = (kstates >= 5'd1) && (kstates <= 5'(NUM_PETS));
  assign k2_range  = (kstates >= 5'(NUM_PETS+1)) && (kstates <= 5'(2*NUM_PETS));
  assign k1_sel    = SEL_W'(kstates - 5'd1);
  assign k2_sel    = SEL_W'(kstates - 5'(NUM_PETS+1));
  assign sel1_ok   = (cur_state == S_SEL1) && key_fire && k1_range &&
                     (fld(pets[p1_idx(k1_sel)], FLD_HP) != '0);
  assign sel2_ok   = (cur_state == S_SEL2) && key_fire && k2_range &&
                     (fld(pets[p2_idx(k2_sel)], FLD_HP) != '0);
  assign atk_hit   = key_fire && (kstates == 5'(ATK_KEY));
  assign atk1_turn = (cur_state == S_ATK1);
  assign gen_last  = (gen_cnt == IDX_W'(TOTAL-1));

  assign p1_word = pets[p1_idx(p1_sel)];
  assign p2_word = pets[p2_idx(p2_sel)];

`ifdef PB_CRIT_EN
  assign crit = rand_vld && rand_in[0];
`else
  assign crit = 1'b0;
`endif

  pet_damage_calc #(.STAT_W(STAT_W)) u_p1_hits (
    .atk(fld(p1_word, FLD_ATK)), .def(fld(p2_word, FLD_DEF)), .hp(fld(p2_word, FLD_HP)),
    .crit(crit), .hp_new(hp_new_p2), .fainted(fainted_p2)
  );

  pet_damage_calc #(.STAT_W(STAT_W)) u_p2_hits (
    .atk(fld(p2_word, FLD_ATK)), .def(fld(p1_word, FLD_DEF)), .hp(fld(p1_word, FLD_HP)),
    .crit(crit), .hp_new(hp_new_p1), .fainted(fainted_p1)
  );

  // Survivor check excludes the active pet, so it reflects post-hit HP in the same cycle.
  always_comb begin
    p1_other_live = 1'b0;
    p2_other_live = 1'b0;
    for (int j = 0; j < NUM_PETS; j++) begin
      if (SEL_W'(j) != p1_sel && fld(pets[j], FLD_HP) != '0) p1_other_live = 1'b1;
      if (SEL_W'(j) != p2_sel && fld(pets[NUM_PETS+j], FLD_HP) != '0) p2_other_live = 1'b1;
    end
  end

  assign def_idx        = atk1_turn ? p2_idx(p2_sel) : p1_idx(p1_sel);
  assign hp_new         = atk1_turn ? hp_new_p2 : hp_new_p1;
  assign def_fainted    = atk1_turn ? fainted_p2 : fainted_p1;
  assign def_other_live = atk1_turn ? p2_other_live : p1_other_live;

  assign rd_stats = (int'(rd_idx) < TOTAL) ? pets[rd_idx] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE: if (start) nxt_state = S_GEN;
      S_GEN:  if (rand_vld && gen_last) nxt_state = S_SEL1;
      S_SEL1: if (sel1_ok) nxt_state = resel ? S_ATK1 : S_SEL2;
      S_SEL2: if (sel2_ok) nxt_state = resel ? S_ATK2 : S_ATK1;
      S_ATK1: if (atk_hit) nxt_state = !fainted_p2 ? S_ATK2 : (p2_other_live ? S_SEL2 : S_OVER);
      S_ATK2: if (atk_hit) nxt_state = !fainted_p1 ? S_ATK1 : (p1_other_live ? S_SEL1 : S_OVER);
      S_OVER: if (start) nxt_state = S_GEN;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    state = cur_state;
    done  = (cur_state == S_OVER);
  end

  // NOTE: the stat array is reset like any register so no stale pet survives a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TOTAL; i++) pets[i] <= '0;
      gen_cnt   <= '0;
      p1_sel    <= '0;
      p2_sel    <= '0;
      winner    <= WIN_NONE;
      resel     <= 1'b0;
      key_armed <= 1'b0;
    end else begin
      key_armed <= (kstates == KEY_NONE);
      case (cur_state)
        S_GEN: if (rand_vld) begin
          pets[gen_cnt] <= force_nonzero(rand_in);
          gen_cnt       <= gen_last ? '0 : gen_cnt + IDX_W'(1);
        end
        S_SEL1: if (sel1_ok) begin
          p1_sel <= k1_sel;
          resel  <= 1'b0;
        end
        S_SEL2: if (sel2_ok) begin
          p2_sel <= k2_sel;
          resel  <= 1'b0;
        end
        S_ATK1, S_ATK2: if (atk_hit) begin
          pets[def_idx][FLD_HP*STAT_W +: STAT_W] <= hp_new;
          if (def_fainted) begin
            if (def_other_live) resel  <= 1'b1;
            else                winner <= atk1_turn ? WIN_P1 : WIN_P2;
          end
        end
        S_OVER: if (start) begin
          for (int i = 0; i < TOTAL; i++) pets[i] <= '0;
          gen_cnt <= '0;
          winner  <= WIN_NONE;
          resel   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pet_battle_engine.sv
// Directed bench for pet_battle_engine at NUM_PETS=4, STAT_W=3, ATK_KEY=14 (PB_CRIT_EN aware).
module tb_pet_battle_engine;
  import pet_battle_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] kstates;
  logic       start;
  logic [8:0] rand_in;
  logic       rand_vld;
  logic [2:0] rd_idx;
  logic [8:0] rd_stats;
  logic [3:0] state;
  logic [1:0] p1_sel, p2_sel, winner;
  logic       done;

  int checks = 0;
  int errors = 0;

  pet_battle_engine #(.NUM_PETS(4), .STAT_W(3), .ATK_KEY(14)) dut (
    .clk(clk), .reset(reset), .kstates(kstates), .start(start),
    .rand_in(rand_in), .rand_vld(rand_vld), .rd_idx(rd_idx), .rd_stats(rd_stats),
    .state(state), .p1_sel(p1_sel), .p2_sel(p2_sel), .winner(winner), .done(done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stat(input int idx, input logic [8:0] exp, input string tag);
    rd_idx = 3'(idx);
    #1;
    check(tag, 32'(rd_stats), 32'(exp));
  endtask

  task automatic press(input logic [4:0] k);
    kstates = k;
    step();
    kstates = 5'd0;
    step();
  endtask

  task automatic gen_word(input logic [8:0] w);
    rand_vld = 1'b1;
    rand_in  = w;
    step();
    rand_vld = 1'b0;
    rand_in  = '0;
  endtask

  task automatic gen_all(input logic [8:0] w);
    for (int i = 0; i < 8; i++) gen_word(w);
  endtask

  initial begin
    reset = 1'b0; kstates = '0; start = 1'b0; rand_in = '0; rand_vld = 1'b0; rd_idx = '0;
    repeat (2) step();
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_done", 32'(done), 32'd0);
    check("reset_winner", 32'(winner), 32'd0);
    reset = 1'b1;
    step();

    start = 1'b1; step(); start = 1'b0;
    check("idle_to_gen", 32'(state), 32'(S_GEN));

    gen_word(9'b011_010_101);
    gen_word(9'b000_000_000);
    step();
    check("gen_hold_state", 32'(state), 32'(S_GEN));
    stat(2, 9'd0, "gen_hold_nowrite");
    gen_word(9'b001_001_001);
    gen_word(9'b000_101_000);
    gen_word(9'b001_111_001);
    gen_word(9'b011_001_011);
    gen_word(9'b000_000_000);
    check("gen_not_done", 32'(state), 32'(S_GEN));
    gen_word(9'b001_001_001);
    check("gen_to_sel1", 32'(state), 32'(S_SEL1));
    stat(0, 9'b011_010_101, "pet0_stats");
    stat(1, 9'b001_001_001, "pet1_zero_forced");
    stat(3, 9'b001_101_001, "pet3_partial_forced");

    start = 1'b1; step(); start = 1'b0;
    check("start_ignored_sel1", 32'(state), 32'(S_SEL1));

    kstates = 5'd2;
    step();
    check("key2_sel_state", 32'(state), 32'(S_SEL2));
    check("key2_p1_sel", 32'(p1_sel), 32'd1);
    repeat (4) step();
    check("key2_held_state", 32'(state), 32'(S_SEL2));
    check("key2_held_p1_sel", 32'(p1_sel), 32'd1);
    kstates = 5'd0;
    step();

    press(5'd5);
    check("p2_sel_state", 32'(state), 32'(S_ATK1));
    check("p2_sel_val", 32'(p2_sel), 32'd0);

    press(5'd14);
    check("atk1v7_forced_sel2", 32'(state), 32'(S_SEL2));
    stat(4, 9'b001_111_000, "atk1v7_hp0");
    press(5'd5);
    check("p2_dead_pet_ignored", 32'(state), 32'(S_SEL2));
    press(5'd6);
    check("p2_resel_to_atk2", 32'(state), 32'(S_ATK2));
    check("p2_resel_val", 32'(p2_sel), 32'd1);

    press(5'd14);
    check("p1_forced_sel1", 32'(state), 32'(S_SEL1));
    stat(1, 9'b001_001_000, "p1_pet1_hp0");
    press(5'd2);
    check("p1_dead_pet_ignored", 32'(state), 32'(S_SEL1));
    check("p1_dead_pet_sel", 32'(p1_sel), 32'd1);
    press(5'd1);
    check("p1_resel_to_atk1", 32'(state), 32'(S_ATK1));
    check("p1_resel_val", 32'(p1_sel), 32'd0);

    kstates = 5'd14;
    repeat (3) step();
    check("atk_held_once", 32'(state), 32'(S_ATK2));
    kstates = 5'd0;
    step();
    stat(5, 9'b011_001_001, "atk3v1_hp3to1");

    rand_vld = 1'b1; rand_in = 9'd0; kstates = 5'd14;
    step();
    rand_vld = 1'b0; kstates = 5'd0;
    step();
    check("atk2_to_atk1", 32'(state), 32'(S_ATK1));
    stat(0, 9'b011_010_100, "atk3v2_hp5to4");

    press(5'd14);
    check("sat_forced_sel2", 32'(state), 32'(S_SEL2));
    stat(5, 9'b011_001_000, "dmg2_hp1_saturate");
    press(5'd7);
    check("p2_pet6_atk2", 32'(state), 32'(S_ATK2));
    press(5'd14);
    check("pet6_hit_atk1", 32'(state), 32'(S_ATK1));
    stat(0, 9'b011_010_011, "pet0_hp3");
    press(5'd14);
    check("pet6_dead_sel2", 32'(state), 32'(S_SEL2));
    press(5'd8);
    check("p2_pet7_sel", 32'(p2_sel), 32'd3);
    press(5'd14);
    stat(0, 9'b011_010_010, "pet0_hp2");
    press(5'd14);
    check("over_state", 32'(state), 32'(S_OVER));
    check("over_winner", 32'(winner), 32'(WIN_P1));
    check("over_done", 32'(done), 32'd1);
    step();
    check("over_winner_held", 32'(winner), 32'(WIN_P1));

    start = 1'b1; step(); start = 1'b0;
    check("restart_gen", 32'(state), 32'(S_GEN));
    check("restart_winner", 32'(winner), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    stat(0, 9'd0, "restart_cleared");

    gen_all(9'b111_001_111);
    press(5'd1);
    press(5'd5);
    check("reset_setup_atk1", 32'(state), 32'(S_ATK1));
    reset = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'(S_IDLE));
    check("midrst_winner", 32'(winner), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) stat(i, 9'd0, "midrst_stats");
    reset = 1'b1;
    step();

    start = 1'b1; step(); start = 1'b0;
    gen_all(9'b111_001_111);
    press(5'd1);
    press(5'd5);
    check("crit_setup_atk1", 32'(state), 32'(S_ATK1));
    rand_vld = 1'b1; rand_in = 9'b000_000_001; kstates = 5'd14;
    step();
    rand_vld = 1'b0; rand_in = '0; kstates = 5'd0;
    step();
`ifdef PB_CRIT_EN
    check("crit_state", 32'(state), 32'(S_SEL2));
    stat(4, 9'b111_001_000, "crit_dmg7_hp0");
`else
    check("nocrit_state", 32'(state), 32'(S_ATK2));
    stat(4, 9'b111_001_001, "nocrit_dmg6_hp1");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
